calc_sequencer: RTL and testbench

- Sequential controller for the calculator datapath.
- Accepts one operation at a time through a start/busy/done handshake.
- Time-multiplexes a single 6-bit ripple adder instance (two 6-bit inputs, carry-in tied 0, 6-bit sum, signed-overflow output) to perform ADD, SUB and unsigned MUL.
- Sits between the operand/keypad front end and the result display register.

---
 rtl/calc_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_calc_sequencer.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/calc_sequencer.sv
// calc_sequencer: multi-cycle calculator controller that runs ADD, SUB and
// unsigned MUL through one shared 6-bit ripple adder.
// Handshake: start is accepted in IDLE; busy covers the operation and the DONE
// cycle; done pulses for one cycle when result/ovf/err change.

// 6-bit ripple-carry adder with carry-in tied low and signed-overflow output.
module calc_ripple_adder #(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] sum,
   output logic             ovf
);
   logic [WIDTH:0] carry;

   assign carry[0] = 1'b0;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
         assign sum[gi]      = x[gi] ^ y[gi] ^ carry[gi];
         assign carry[gi+1]  = (x[gi] & y[gi]) | (carry[gi] & (x[gi] ^ y[gi]));
      end
   endgenerate

   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign ovf = carry[WIDTH] ^ carry[WIDTH-1];
endmodule

module calc_sequencer #(
   parameter int WIDTH = 6
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             ovf,
   output logic             err
);
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_NEGB = 3'd1;
   localparam logic [2:0] S_ADD  = 3'd2;
   localparam logic [2:0] S_MUL  = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_RSV = 2'b11;

   localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
   localparam logic [2:0]       LAST_BIT = 3'(WIDTH - 1);

   logic [2:0]         state_reg, state_next;
   logic [WIDTH-1:0]   a_reg, b_reg, temp_reg, acc_reg;
   logic [1:0]         op_reg;
   logic [2:0]         cnt_reg;
   logic               mul_ovf_reg;
   logic [WIDTH-1:0]   result_reg;
   logic               ovf_reg, err_reg;

   // Shared adder port signals
   logic [WIDTH-1:0]   add_x, add_y, add_sum;
   logic               add_ovf;

   // Multiply step helpers
   logic [2*WIDTH-1:0] shifted;
   logic               mul_bit, carry5, lost_bits;
   logic [WIDTH-1:0]   acc_next;
   logic               mul_ovf_next;

   calc_ripple_adder #(.WIDTH(WIDTH)) u_adder (
      .x   (add_x),
      .y   (add_y),
      .sum (add_sum),
      .ovf (add_ovf)
   );

   // Partial product A<<i kept at double width so bits pushed past the top are visible.
   assign shifted   = {{WIDTH{1'b0}}, a_reg} << cnt_reg;
   assign mul_bit   = b_reg[cnt_reg];
   assign lost_bits = |shifted[2*WIDTH-1:WIDTH];
   // Carry out of the top bit, recovered from operands and sum of that bit.
   assign carry5    = (add_x[WIDTH-1] & add_y[WIDTH-1]) |
                      ((add_x[WIDTH-1] ^ add_y[WIDTH-1]) & ~add_sum[WIDTH-1]);
   assign acc_next     = mul_bit ? add_sum : acc_reg;
   assign mul_ovf_next = mul_ovf_reg | (mul_bit & (lost_bits | carry5));

   // Steer the single adder according to the current step.
   always_comb begin
      add_x = a_reg;
      add_y = b_reg;
      case (state_reg)
         S_NEGB: begin
            add_x = ~b_reg;
            add_y = ONE;
         end
         S_ADD: begin
            add_x = a_reg;
            add_y = (op_reg == OP_SUB) ? temp_reg : b_reg;
         end
         S_MUL: begin
            add_x = acc_reg;
            add_y = shifted[WIDTH-1:0];
         end
         default: ;
      endcase
   end

   // Next-state selection; the reserved op borrows the ADD slot so its latency matches ADD.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               case (op)
                  OP_SUB:  state_next = S_NEGB;
                  OP_MUL:  state_next = S_MUL;
                  default: state_next = S_ADD;
               endcase
            end
         end
         S_NEGB:  state_next = S_ADD;
         S_ADD:   state_next = S_DONE;
         S_MUL:   state_next = (cnt_reg == LAST_BIT) ? S_DONE : S_MUL;
         S_DONE:  state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   // State, operand latches, accumulator and output registers.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= S_IDLE;
         a_reg       <= '0;
         b_reg       <= '0;
         op_reg      <= OP_ADD;
         temp_reg    <= '0;
         acc_reg     <= '0;
         cnt_reg     <= '0;
         mul_ovf_reg <= 1'b0;
         result_reg  <= '0;
         ovf_reg     <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg <= state_next;
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  a_reg       <= a;
                  b_reg       <= b;
                  op_reg      <= op;
                  acc_reg     <= '0;
                  cnt_reg     <= '0;
                  mul_ovf_reg <= 1'b0;
               end
            end
            S_NEGB: temp_reg <= add_sum;
            S_ADD: begin
               if (op_reg == OP_RSV) begin
                  result_reg <= '0;
                  ovf_reg    <= 1'b0;
                  err_reg    <= 1'b1;
               end else begin
                  result_reg <= add_sum;
                  // Negating the most negative B overflows silently; flip to get A-B overflow.
                  ovf_reg    <= (op_reg == OP_SUB) ? (add_ovf ^ (b_reg == MOST_NEG)) : add_ovf;
                  err_reg    <= 1'b0;
               end
            end
            S_MUL: begin
               acc_reg     <= acc_next;
               mul_ovf_reg <= mul_ovf_next;
               if (cnt_reg == LAST_BIT) begin
                  result_reg <= acc_next;
                  ovf_reg    <= mul_ovf_next;
                  err_reg    <= 1'b0;
               end else begin
                  cnt_reg <= cnt_reg + 3'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy   = (state_reg != S_IDLE);
   assign done   = (state_reg == S_DONE);
   assign result = result_reg;
   assign ovf    = ovf_reg;
   assign err    = err_reg;
endmodule

// File: tb/tb_calc_sequencer.sv
// Directed testbench for calc_sequencer: latency, results, flags, handshake and reset abort.
module tb_calc_sequencer;
   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [1:0] op;
   logic [5:0] a, b;
   logic       busy, done, ovf, err;
   logic [5:0] result;

   int checks = 0;
   int errors = 0;
   logic [5:0] prev_result;

   calc_sequencer #(.WIDTH(6)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (start),
      .op     (op),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .done   (done),
      .result (result),
      .ovf    (ovf),
      .err    (err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Launch one operation from IDLE and check every cycle up to the return to IDLE.
   // lat = cycle index (counting the accept edge as N) in which done is high.
   task automatic run_op(input string tag, input logic [1:0] o, input logic [5:0] av,
                         input logic [5:0] bv, input int lat, input logic [5:0] er,
                         input logic eo, input logic ee);
      op = o; a = av; b = bv; start = 1'b1;
      step();
      start = 1'b0;
      a = 6'($urandom); b = 6'($urandom); op = 2'($urandom);
      chk({tag, ".busy_n1"}, {7'd0, busy}, 8'd1);
      chk({tag, ".done_n1"}, {7'd0, done}, 8'd0);
      chk({tag, ".hold_n1"}, {2'd0, result}, {2'd0, prev_result});
      for (int j = 2; j < lat; j++) begin
         step();
         chk({tag, ".busy_mid"}, {7'd0, busy}, 8'd1);
         chk({tag, ".done_mid"}, {7'd0, done}, 8'd0);
      end
      step();
      chk({tag, ".done"},   {7'd0, done}, 8'd1);
      chk({tag, ".busy_d"}, {7'd0, busy}, 8'd1);
      chk({tag, ".result"}, {2'd0, result}, {2'd0, er});
      chk({tag, ".ovf"},    {7'd0, ovf},  {7'd0, eo});
      chk({tag, ".err"},    {7'd0, err},  {7'd0, ee});
      $display("txn %s op=%0d a=%02h b=%02h -> result=%02h ovf=%0b err=%0b",
               tag, o, av, bv, result, ovf, err);
      step();
      chk({tag, ".busy_end"}, {7'd0, busy}, 8'd0);
      chk({tag, ".done_end"}, {7'd0, done}, 8'd0);
      prev_result = er;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
      prev_result = '0;
      step();
      step();
      chk("rst.busy",   {7'd0, busy}, 8'd0);
      chk("rst.done",   {7'd0, done}, 8'd0);
      chk("rst.result", {2'd0, result}, 8'd0);
      chk("rst.ovf",    {7'd0, ovf}, 8'd0);
      chk("rst.err",    {7'd0, err}, 8'd0);
      $display("txn reset");
      rst_n = 1'b1;
      step();

      run_op("add5p3",   2'b00, 6'b000101, 6'b000011, 2, 6'b001000, 1'b0, 1'b0);
      run_op("add_ovf",  2'b00, 6'b011111, 6'b000001, 2, 6'b100000, 1'b1, 1'b0);
      run_op("sub_mneg", 2'b01, 6'b000000, 6'b100000, 3, 6'b100000, 1'b1, 1'b0);
      run_op("sub3m5",   2'b01, 6'b000011, 6'b000101, 3, 6'b111110, 1'b0, 1'b0);
      run_op("sub_m1",   2'b01, 6'b111111, 6'b100000, 3, 6'b011111, 1'b0, 1'b0);
      run_op("mul7x5",   2'b10, 6'b000111, 6'b000101, 7, 6'b100011, 1'b0, 1'b0);
      run_op("mul8x8",   2'b10, 6'b001000, 6'b001000, 7, 6'b000000, 1'b1, 1'b0);
      run_op("mul63x1",  2'b10, 6'b111111, 6'b000001, 7, 6'b111111, 1'b0, 1'b0);
      run_op("mul31x3",  2'b10, 6'b011111, 6'b000011, 7, 6'b011101, 1'b1, 1'b0);
      run_op("mul9x7",   2'b10, 6'b001001, 6'b000111, 7, 6'b111111, 1'b0, 1'b0);

      // start held high: one ADD every three cycles, none accepted while busy
      op = 2'b00; a = 6'd1; b = 6'd2; start = 1'b1;
      for (int k = 0; k < 9; k++) begin
         step();
         chk("hold.busy", {7'd0, busy}, (k % 3 != 2) ? 8'd1 : 8'd0);
         chk("hold.done", {7'd0, done}, (k % 3 == 1) ? 8'd1 : 8'd0);
      end
      start = 1'b0;
      chk("hold.result", {2'd0, result}, 8'd3);
      $display("txn hold_start three ADDs result=%02h", result);
      prev_result = 6'd3;

      run_op("reserved", 2'b11, 6'b010101, 6'b001010, 2, 6'b000000, 1'b0, 1'b1);
      run_op("add_clr",  2'b00, 6'b000001, 6'b000001, 2, 6'b000010, 1'b0, 1'b0);

      // reset during MUL iteration 3 aborts without a done pulse
      op = 2'b10; a = 6'b000111; b = 6'b000101; start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      rst_n = 1'b0;
      step();
      chk("abort.busy",   {7'd0, busy}, 8'd0);
      chk("abort.done",   {7'd0, done}, 8'd0);
      chk("abort.result", {2'd0, result}, 8'd0);
      chk("abort.ovf",    {7'd0, ovf}, 8'd0);
      chk("abort.err",    {7'd0, err}, 8'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 8; k++) begin
         step();
         chk("abort.no_done", {7'd0, done}, 8'd0);
         chk("abort.idle",    {7'd0, busy}, 8'd0);
      end
      $display("txn reset_abort mul");
      prev_result = '0;
      run_op("post_rst", 2'b00, 6'b000101, 6'b000011, 2, 6'b001000, 1'b0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
